game_status_scanner: RTL and testbench



---
 rtl/game_status_scanner.sv | 161 ++++++++++++++++
 tb/tb_game_status_scanner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_status_scanner.sv
// Sequential board scanner: snapshots an N x N board on request, then walks it one
// cell per clock to produce win / lose / empty-count results.
module game_status_scanner #(
  parameter int N       = 4,
  parameter int TILE_W  = 12,
  parameter int MAX_WIN = 11
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [N-1:0][N-1:0][TILE_W-1:0]       board_in,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  win,
  output logic                                  lose,
  output logic [$clog2(N*N+1)-1:0]              empty_count
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int EW = $clog2(N*N+1);
  localparam logic [TILE_W-1:0] WIN_TH = TILE_W'(1) << MAX_WIN;
  localparam logic [CW-1:0]     LAST_RC = CW'(N-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SNAP = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [N-1:0][N-1:0][TILE_W-1:0] r_snap;
  logic [CW-1:0]                   r_row;
  logic [CW-1:0]                   r_col;
  logic                            r_win_acc;
  logic                            r_merge_acc;
  logic [EW-1:0]                   r_zero_cnt;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_win;
  logic                            r_lose;
  logic [EW-1:0]                   r_empty;

  logic                            w_last;
  logic [CW-1:0]                   w_col_nb;
  logic [CW-1:0]                   w_row_nb;
  logic [TILE_W-1:0]               w_cell;
  logic [TILE_W-1:0]               w_right;
  logic [TILE_W-1:0]               w_down;
  logic                            w_is_zero;
  logic                            w_hit_merge;
  logic                            w_win_acc;
  logic                            w_merge_acc;
  logic [EW-1:0]                   w_zero_acc;

  assign w_last    = (r_row == LAST_RC) && (r_col == LAST_RC);
  // Neighbour indices are clamped on the last column/row; the has-neighbour test masks them.
  assign w_col_nb  = (r_col == LAST_RC) ? r_col : r_col + CW'(1);
  assign w_row_nb  = (r_row == LAST_RC) ? r_row : r_row + CW'(1);
  assign w_cell    = r_snap[r_row][r_col];
  assign w_right   = r_snap[r_row][w_col_nb];
  assign w_down    = r_snap[w_row_nb][r_col];
  assign w_is_zero = (w_cell == {TILE_W{1'b0}});
  assign w_hit_merge = !w_is_zero &&
                       (((r_col != LAST_RC) && (w_cell == w_right)) ||
                        ((r_row != LAST_RC) && (w_cell == w_down)));
  assign w_win_acc   = r_win_acc | (w_cell >= WIN_TH);
  assign w_merge_acc = r_merge_acc | w_hit_merge;
  assign w_zero_acc  = r_zero_cnt + (w_is_zero ? EW'(1) : EW'(0));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SNAP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SNAP: w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Snapshot, scan accumulators and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_win_acc   <= 1'b0;
      r_merge_acc <= 1'b0;
      r_zero_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
      r_empty     <= '0;
    end else begin
      r_busy <= (w_state_nxt == S_SNAP) || (w_state_nxt == S_SCAN);
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_SNAP: begin
          r_snap      <= board_in;
          r_row       <= '0;
          r_col       <= '0;
          r_win_acc   <= 1'b0;
          r_merge_acc <= 1'b0;
          r_zero_cnt  <= '0;
        end
        S_SCAN: begin
          r_win_acc   <= w_win_acc;
          r_merge_acc <= w_merge_acc;
          r_zero_cnt  <= w_zero_acc;
          if (r_col == LAST_RC) begin
            r_col <= '0;
            r_row <= r_row + CW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
          // Results are loaded on the edge into DONE, including the final cell.
          if (w_last) begin
            r_win   <= w_win_acc;
            r_empty <= w_zero_acc;
            r_lose  <= (w_zero_acc == EW'(0)) && !w_merge_acc && !w_win_acc;
          end
        end
        default: begin
          r_row <= r_row;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign win         = r_win;
  assign lose        = r_lose;
  assign empty_count = r_empty;

endmodule

// File: tb/tb_game_status_scanner.sv
// Randomized self-checking bench for game_status_scanner (N=4 and N=2 instances)
// against a rule-level reference model.
module tb_game_status_scanner;

  localparam int N   = 4;
  localparam int TW  = 12;
  localparam int MW  = 11;
  localparam int EW  = $clog2(N*N+1);
  localparam int N2  = 2;
  localparam int TW2 = 8;
  localparam int MW2 = 5;
  localparam int EW2 = $clog2(N2*N2+1);

  typedef logic [N-1:0][N-1:0][TW-1:0]    board4_t;
  typedef logic [N2-1:0][N2-1:0][TW2-1:0] board2_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  board4_t       board_in = '0;
  logic          busy, done, win, lose;
  logic [EW-1:0] empty_count;

  logic           start2 = 1'b0;
  board2_t        board2 = '0;
  logic           busy2, done2, win2, lose2;
  logic [EW2-1:0] empty2;

  int errors = 0;
  int checks = 0;
  int prev_w = 0, prev_l = 0, prev_e = 0;

  game_status_scanner #(.N(N), .TILE_W(TW), .MAX_WIN(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in),
    .busy(busy), .done(done), .win(win), .lose(lose), .empty_count(empty_count)
  );

  game_status_scanner #(.N(N2), .TILE_W(TW2), .MAX_WIN(MW2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .board_in(board2),
    .busy(busy2), .done(done2), .win(win2), .lose(lose2), .empty_count(empty2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rule-level model: any tile >= 2**mw wins; lose = full board, no equal nonzero neighbours, no win.
  task automatic model(input int cells[64], input int n, input int mw,
                       output int w, output int l, output int e);
    int m;
    int v;
    w = 0; e = 0; m = 0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        v = cells[r*n+c];
        if (v >= (1 << mw)) w = 1;
        if (v == 0) e++;
        if (v != 0 && c+1 < n && cells[r*n+c+1] == v) m = 1;
        if (v != 0 && r+1 < n && cells[(r+1)*n+c] == v) m = 1;
      end
    end
    l = (e == 0 && m == 0 && w == 0) ? 1 : 0;
  endtask

  function automatic int rnd_tile(input int lo, input int hi);
    int ex;
    ex = $urandom_range(hi, lo);
    return (ex == 0) ? 0 : (1 << ex);
  endfunction

  task automatic rand4(input int lo, input int hi, output board4_t b);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        b[r][c] = TW'(rnd_tile(lo, hi));
  endtask

  task automatic run4(input string tag, input board4_t b, input int tweak_k, input bit restart_in_done);
    int cells[64];
    int ew, el, ee, lat, extra;
    bit busy_ok;
    board4_t junk;
    for (int i = 0; i < 64; i++) cells[i] = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        cells[r*N+c] = int'(b[r][c]);
    model(cells, N, MW, ew, el, ee);
    @(negedge clk);
    board_in = b;
    start = 1'b1;
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k == 10) begin
        check_eq({tag, ".hold_win"}, win, prev_w);
        check_eq({tag, ".hold_lose"}, lose, prev_l);
        check_eq({tag, ".hold_empty"}, empty_count, prev_e);
      end
      if (k == tweak_k) begin
        rand4(0, 11, junk);
        board_in = junk;
        start = 1'b1;
      end
      if (k == tweak_k + 1) start = 1'b0;
    end
    check_eq({tag, ".latency"}, lat, 2 + N*N);
    check_eq({tag, ".busy_during"}, busy_ok, 1);
    check_eq({tag, ".busy_at_done"}, busy, 0);
    check_eq({tag, ".win"}, win, ew);
    check_eq({tag, ".lose"}, lose, el);
    check_eq({tag, ".empty"}, empty_count, ee);
    prev_w = ew; prev_l = el; prev_e = ee;
    if (restart_in_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, ".done_pulse"}, done, 0);
    extra = 0;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check_eq({tag, ".no_rescan"}, extra, 0);
  endtask

  task automatic run2(input string tag, input board2_t b);
    int cells[64];
    int ew, el, ee, lat;
    for (int i = 0; i < 64; i++) cells[i] = 0;
    for (int r = 0; r < N2; r++)
      for (int c = 0; c < N2; c++)
        cells[r*N2+c] = int'(b[r][c]);
    model(cells, N2, MW2, ew, el, ee);
    @(negedge clk);
    board2 = b;
    start2 = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) start2 = 1'b0;
      if (done2) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, ".latency"}, lat, 2 + N2*N2);
    check_eq({tag, ".win"}, win2, ew);
    check_eq({tag, ".lose"}, lose2, el);
    check_eq({tag, ".empty"}, empty2, ee);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    board4_t b;
    board2_t b2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.busy", busy, 0);
    check_eq("reset.done", done, 0);
    check_eq("reset.win", win, 0);
    check_eq("reset.lose", lose, 0);
    check_eq("reset.empty", empty_count, 0);
    @(negedge clk);
    rst = 1'b0;

    b = '0;
    run4("zero", b, -5, 1'b0);
    b[1][1] = 12'd2048;
    run4("win2048", b, -5, 1'b0);
    b = '0;
    b[3][3] = 12'd4096 - 12'd1;
    b[3][3] = 12'd2049;
    run4("win_gt", b, -5, 1'b0);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        b[r][c] = (((r + c) % 2) != 0) ? 12'd4 : 12'd2;
    run4("checker", b, -5, 1'b0);
    b[3][2] = b[3][3];
    run4("hpair_last_row", b, -5, 1'b0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        b[r][c] = (((r + c) % 2) != 0) ? 12'd4 : 12'd2;
    b[2][0] = b[3][0];
    run4("vpair", b, -5, 1'b0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        b[r][c] = (((r + c) % 2) != 0) ? 12'd4 : 12'd2;
    b[0][0] = 12'd2048;
    run4("full_win", b, -5, 1'b0);

    b = '0;
    b[2][1] = 12'd128;
    run4("snapshot", b, 5, 1'b1);

    // Reset while the scan is at cell 7
    @(negedge clk);
    board_in = b;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst.busy", busy, 0);
    check_eq("midrst.done", done, 0);
    check_eq("midrst.win", win, 0);
    check_eq("midrst.lose", lose, 0);
    check_eq("midrst.empty", empty_count, 0);
    rst = 1'b0;
    prev_w = 0; prev_l = 0; prev_e = 0;
    b = '0;
    b[0][3] = 12'd8;
    run4("after_rst", b, -5, 1'b0);

    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0:       rand4(0, 11, b);
        1:       rand4(1, 3, b);
        default: rand4(1, 11, b);
      endcase
      run4("rand4", b, ((i % 4) == 0) ? 3 + (i % 12) : -5, (i % 5) == 0);
    end

    b2[0][0] = 8'd2; b2[0][1] = 8'd4; b2[1][0] = 8'd4; b2[1][1] = 8'd2;
    run2("n2_lose", b2);
    b2 = '0;
    b2[0][0] = 8'd32;
    run2("n2_win", b2);
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < N2; r++)
        for (int c = 0; c < N2; c++)
          b2[r][c] = TW2'(rnd_tile((i % 2 == 0) ? 0 : 1, (i % 3 == 0) ? 7 : 2));
      run2("n2_rand", b2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
